// File: rtl/clk_strobe_gen_pkg.sv
// Shared types and helpers for the clock-enable generator: lock FSM states,
// config channel width and reset-divisor extraction.
package clk_strobe_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        LOCKED = 2'd1,
        PEND   = 2'd2
    } lock_state_e;

    localparam int CFG_CH_W  = 4;
    localparam int MAX_CH    = 16;
    localparam int MAX_DIV_W = 32;
    localparam int INIT_W    = MAX_CH * MAX_DIV_W;

    // Slice i of a packed divisor vector whose slices are div_w bits wide.
    function automatic logic [MAX_DIV_W-1:0] init_div(
        input logic [INIT_W-1:0] init_vec,
        input int unsigned       i,
        input int unsigned       div_w
    );
        logic [INIT_W-1:0]    shifted_s;
        logic [MAX_DIV_W-1:0] mask_s;
        shifted_s = init_vec >> (i * div_w);
        if (div_w >= MAX_DIV_W) begin
            mask_s = {MAX_DIV_W{1'b1}};
        end else begin
            mask_s = (32'd1 << div_w) - 32'd1;
        end
        return shifted_s[MAX_DIV_W-1:0] & mask_s;
    endfunction

endpackage

// File: rtl/clk_strobe_gen_if.sv
// Divisor-update port of the clock-enable generator: valid/ready request
// plus the one-cycle out-of-range error pulse.
interface clk_strobe_gen_if
    import clk_strobe_pkg::*;
#(
    parameter int DIV_W = 16
) ();

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CFG_CH_W-1:0] cfg_ch;
    logic [DIV_W-1:0]    cfg_div;
    logic                cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clk_strobe_gen_ch.sv
// One strobe channel: programmable down-counter producing a one-cycle strobe
// and a divide-by-2 toggle; new divisors are loaded only at terminal count.
module strobe_div_ch #(
    parameter int               DIV_W   = 16,
    parameter logic [DIV_W-1:0] DIV_RST = {{(DIV_W-1){1'b0}}, 1'b1}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_en,
    input  logic [DIV_W-1:0] load_div,
    output logic             tc,
    output logic             strobe,
    output logic             toggle
);

    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    // A disabled channel parks its counter at zero.
    function automatic logic [DIV_W-1:0] reload_val(input logic [DIV_W-1:0] d);
        if (d == '0) begin
            return '0;
        end else begin
            return d - DIV_ONE;
        end
    endfunction

    logic [DIV_W-1:0] div_r, div_nx_s;
    logic [DIV_W-1:0] cnt_r, cnt_nx_s;
    logic             strobe_r, strobe_nx_s;
    logic             toggle_r, toggle_nx_s;

    // Counter, divisor and output next-state.
    always_comb begin
        div_nx_s    = div_r;
        cnt_nx_s    = cnt_r;
        strobe_nx_s = 1'b0;
        toggle_nx_s = toggle_r;
        if (div_r == '0) begin
            toggle_nx_s = 1'b0;
            if (load_en) begin
                div_nx_s = load_div;
                cnt_nx_s = reload_val(load_div);
            end else begin
                cnt_nx_s = '0;
            end
        end else if (cnt_r == '0) begin
            strobe_nx_s = 1'b1;
            toggle_nx_s = ~toggle_r;
            if (load_en) begin
                div_nx_s = load_div;
                cnt_nx_s = reload_val(load_div);
            end else begin
                cnt_nx_s = div_r - DIV_ONE;
            end
        end else begin
            cnt_nx_s = cnt_r - DIV_ONE;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r    <= DIV_RST;
            cnt_r    <= reload_val(DIV_RST);
            strobe_r <= 1'b0;
            toggle_r <= 1'b0;
        end else begin
            div_r    <= div_nx_s;
            cnt_r    <= cnt_nx_s;
            strobe_r <= strobe_nx_s;
            toggle_r <= toggle_nx_s;
        end
    end

    assign tc     = (cnt_r == '0);
    assign strobe = strobe_r;
    assign toggle = toggle_r;

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel clock-enable generator: NUM_CH strobe channels, a single-slot
// divisor update path committed at terminal count, and a settle/lock monitor.
module clk_strobe_gen
    import clk_strobe_pkg::*;
#(
    parameter int                      NUM_CH      = 4,
    parameter int                      DIV_W       = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {NUM_CH{{{(DIV_W-1){1'b0}}, 1'b1}}},
    parameter int                      LOCK_CYCLES = 256
) (
    input  logic              refclk,
    input  logic              rst,
    clk_strobe_gen_if.slave   cfg,
    output logic [NUM_CH-1:0] strobe,
    output logic [NUM_CH-1:0] toggle,
    output logic              locked
);

    localparam int                  LOCK_W      = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [LOCK_W-1:0]   LOCK_RELOAD = LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [LOCK_W-1:0]   LOCK_ONE    = {{(LOCK_W-1){1'b0}}, 1'b1};
    localparam logic [CFG_CH_W:0]   NUM_CH_L    = (CFG_CH_W + 1)'(NUM_CH);

    logic                pend_r;
    logic [CFG_CH_W-1:0] pend_ch_r;
    logic [DIV_W-1:0]    pend_div_r;
    logic                err_r;
    logic                accept_s, ch_oob_s, accept_ok_s, commit_s;
    logic [NUM_CH-1:0]   tc_s, load_en_s;
    lock_state_e         state_r, state_nx_s;
    logic [LOCK_W-1:0]   settle_r, settle_nx_s;
    logic                locked_r, locked_nx_s;

    assign accept_s    = cfg.cfg_valid & ~pend_r;
    assign ch_oob_s    = ({1'b0, cfg.cfg_ch} >= NUM_CH_L);
    assign accept_ok_s = accept_s & ~ch_oob_s;
    assign commit_s    = |load_en_s;

    assign cfg.cfg_ready = ~pend_r;
    assign cfg.cfg_err   = err_r;
    assign locked        = locked_r;

    // Route the pending update to its channel; it lands at that channel's terminal count.
    always_comb begin
        load_en_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            load_en_s[i] = pend_r & (pend_ch_r == CFG_CH_W'(i)) & tc_s[i];
        end
    end

    // Pending update slot and error pulse.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pend_r     <= 1'b0;
            pend_ch_r  <= '0;
            pend_div_r <= '0;
            err_r      <= 1'b0;
        end else begin
            err_r <= accept_s & ch_oob_s;
            if (accept_ok_s) begin
                pend_r     <= 1'b1;
                pend_ch_r  <= cfg.cfg_ch;
                pend_div_r <= cfg.cfg_div;
            end else if (commit_s) begin
                pend_r <= 1'b0;
            end
        end
    end

    // Lock FSM state and settle counter registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r  <= SETTLE;
            settle_r <= LOCK_RELOAD;
            locked_r <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            settle_r <= settle_nx_s;
            locked_r <= locked_nx_s;
        end
    end

    // Lock FSM next-state: any accepted in-range update drops lock until it commits.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            SETTLE: begin
                if (accept_ok_s) begin
                    state_nx_s = PEND;
                end else if (settle_r == '0) begin
                    state_nx_s = LOCKED;
                end else begin
                    state_nx_s = SETTLE;
                end
            end
            LOCKED: begin
                if (accept_ok_s) begin
                    state_nx_s = PEND;
                end else begin
                    state_nx_s = LOCKED;
                end
            end
            PEND: begin
                if (commit_s) begin
                    state_nx_s = SETTLE;
                end else begin
                    state_nx_s = PEND;
                end
            end
            default: state_nx_s = SETTLE;
        endcase
    end

    // Lock FSM outputs: settle countdown and registered locked flag.
    always_comb begin
        settle_nx_s = settle_r;
        locked_nx_s = (state_nx_s == LOCKED);
        case (state_r)
            SETTLE: begin
                if (settle_r != '0) begin
                    settle_nx_s = settle_r - LOCK_ONE;
                end else begin
                    settle_nx_s = settle_r;
                end
            end
            PEND: begin
                if (commit_s) begin
                    settle_nx_s = LOCK_RELOAD;
                end else begin
                    settle_nx_s = settle_r;
                end
            end
            default: settle_nx_s = settle_r;
        endcase
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [DIV_W-1:0] CH_INIT =
            DIV_W'(init_div(INIT_W'(DIV_INIT), g, DIV_W));

        strobe_div_ch #(
            .DIV_W   (DIV_W),
            .DIV_RST (CH_INIT)
        ) u_ch (
            .clk      (refclk),
            .rst      (rst),
            .load_en  (load_en_s[g]),
            .load_div (pend_div_r),
            .tc       (tc_s[g]),
            .strobe   (strobe[g]),
            .toggle   (toggle[g])
        );
    end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Scoreboard bench for clk_strobe_gen: an event-time reference model predicts
// every cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_clk_strobe_gen;
    import clk_strobe_pkg::*;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 16;
    localparam int LOCK   = 8;
    localparam logic [NUM_CH*DIV_W-1:0] DIV_INIT = {16'd0, 16'd2, 16'd3, 16'd4};

    logic              refclk = 1'b0;
    logic              rst    = 1'b1;
    logic [NUM_CH-1:0] strobe, toggle;
    logic              locked;

    clk_strobe_gen_if #(.DIV_W(DIV_W)) cfg_if ();

    clk_strobe_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DIV_INIT    (DIV_INIT),
        .LOCK_CYCLES (LOCK)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .cfg    (cfg_if),
        .strobe (strobe),
        .toggle (toggle),
        .locked (locked)
    );

    always #5 refclk = ~refclk;

    typedef struct packed {
        logic [NUM_CH-1:0] strobe;
        logic [NUM_CH-1:0] toggle;
        logic              locked;
        logic              ready;
        logic              err;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state: absolute times of the next strobe per channel.
    int init_tb [NUM_CH] = '{4, 3, 2, 0};
    int m_div   [NUM_CH];
    int m_next  [NUM_CH];
    bit m_tog   [NUM_CH];
    bit m_pend, m_wait;
    int m_pch, m_pdiv, m_lock_at, cyc;

    initial begin : model
        obs_t e;
        bit   acc, committed;
        int   ch;
        forever begin
            @(posedge refclk);
            e = '0;
            if (rst) begin
                cyc = 0;
                for (int i = 0; i < NUM_CH; i++) begin
                    m_div[i]  = init_tb[i];
                    m_next[i] = init_tb[i];
                    m_tog[i]  = 1'b0;
                end
                m_pend    = 1'b0;
                m_wait    = 1'b0;
                m_lock_at = LOCK;
                e.ready   = 1'b1;
            end else begin
                cyc++;
                ch        = int'(cfg_if.cfg_ch);
                acc       = cfg_if.cfg_valid && !m_pend;
                committed = 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (m_div[i] != 0 && m_next[i] == cyc) begin
                        e.strobe[i] = 1'b1;
                        m_tog[i]    = !m_tog[i];
                        if (m_pend && m_pch == i) begin
                            m_div[i]  = m_pdiv;
                            m_next[i] = cyc + m_pdiv;
                            committed = 1'b1;
                        end else begin
                            m_next[i] = m_next[i] + m_div[i];
                        end
                    end else if (m_div[i] == 0) begin
                        m_tog[i] = 1'b0;
                        if (m_pend && m_pch == i) begin
                            m_div[i]  = m_pdiv;
                            m_next[i] = cyc + m_pdiv;
                            committed = 1'b1;
                        end
                    end
                    e.toggle[i] = m_tog[i];
                end
                if (committed) begin
                    m_pend    = 1'b0;
                    m_wait    = 1'b0;
                    m_lock_at = cyc + LOCK;
                end
                e.err = acc && (ch >= NUM_CH);
                if (acc && ch < NUM_CH) begin
                    m_pend = 1'b1;
                    m_pch  = ch;
                    m_pdiv = int'(cfg_if.cfg_div);
                    m_wait = 1'b1;
                end
                e.ready  = !m_pend;
                e.locked = !m_wait && (cyc >= m_lock_at);
            end
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        obs_t e, act;
        forever begin
            @(negedge refclk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {strobe, toggle, locked, cfg_if.cfg_ready, cfg_if.cfg_err};
                vectors++;
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t cyc=%0d got strobe=%b toggle=%b locked=%b ready=%b err=%b, expected strobe=%b toggle=%b locked=%b ready=%b err=%b",
                             $time, cyc, act.strobe, act.toggle, act.locked, act.ready, act.err,
                             e.strobe, e.toggle, e.locked, e.ready, e.err);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge refclk);
        #1;
        rst = 1'b0;
    endtask

    // Present one request for exactly one edge, once the slot is free.
    task automatic send(input int ch, input int dv);
        int n = 0;
        while (!cfg_if.cfg_ready && n < 200) begin
            @(posedge refclk);
            #1;
            n++;
        end
        if (!cfg_if.cfg_ready) begin
            miscompares++;
            $display("FAIL ready_timeout got ready=%b after %0d cycles, expected 1", cfg_if.cfg_ready, n);
        end
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 4'(ch);
        cfg_if.cfg_div   = 16'(dv);
        @(posedge refclk);
        #1;
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin : stimulus
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = 4'd0;
        cfg_if.cfg_div   = 16'd0;
        rst              = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(5);
        send(0, 6);
        idle(40);
        send(7, 3);
        idle(5);
        send(3, 5);
        idle(30);
        send(2, 1);
        idle(10);
        send(2, 0);
        idle(10);
        send(0, 50);
        idle(10);
        send(0, 3);
        pulse_rst();
        idle(30);
        for (int k = 0; k < 400; k++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r < 4 && cfg_if.cfg_ready) begin
                send(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end else if (r == 15 && $urandom_range(0, 9) == 0) begin
                pulse_rst();
            end else begin
                idle(1);
            end
        end
        idle(3);
        @(negedge refclk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d queued, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clk_strobe_gen.md
# clk_strobe_gen

Parametrised, runtime-reconfigurable clock-enable generator: from one fabric clock it produces NUM_CH independent periodic strobes and derived square-wave toggles, plus a `locked` indication. It is the next generation of the team's fixed multi-output PLL wrapper. Slow peripheral rates are produced as enables in one clock domain instead of extra PLL outputs, and divisors can be changed at run time through a valid/ready port. It sits beside the PLL and feeds the SCOMP peripherals (timers, tone and UART rate logic).

## Interface
- NUM_CH, 4, number of output channels (1..16)
- DIV_W, 16, divisor width in bits
- DIV_INIT, {NUM_CH{16'd1}}, packed reset divisors; channel i uses bits [i*DIV_W +: DIV_W]
- LOCK_CYCLES, 256, settle cycles before `locked` asserts (≥1)

- refclk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- cfg_valid  in  1  divisor update request
- cfg_ready  out  1  update can be accepted
- cfg_ch  in  4  target channel index
- cfg_div  in  DIV_W  new divisor; 0 disables the channel
- cfg_err  out  1  one-cycle pulse: accepted request had cfg_ch ≥ NUM_CH
- strobe  out  NUM_CH  one-cycle enable per channel period
- toggle  out  NUM_CH  flips on each strobe, giving a period of 2·div
- locked  out  1  all channels running on committed divisors and settled

## Operation
- Per channel: registered `div` and a down-counter `cnt`.
  - On reset: `div` = DIV_INIT slice; `cnt` = div−1.
  - Each cycle with div≠0: if cnt==0, assert strobe, flip toggle, reload cnt = div−1 (using the pending divisor if one is due, see below); otherwise decrement cnt.
  - div==0: strobe=0, toggle=0, cnt held at 0.
  - div==1: strobe high every cycle; toggle flips every cycle.
- Config handshake:
  - A request transfers when cfg_valid & cfg_ready.
  - One pending slot (channel, divisor); cfg_ready = !pending.
  - An accepted request with an out-of-range channel is dropped. cfg_err pulses the next cycle, no slot is used, and `locked` is unaffected.
- Applying a pending update (glitch-free):
  - It is committed at the target channel's next terminal count (cnt==0). The strobe on that cycle still fires under the old divisor, and the reload uses new_div−1.
  - If the target is disabled (div==0), it is committed on the cycle after acceptance, with cnt = new_div−1.
  - Committing new_div=0 forces strobe and toggle low from the next cycle.
  - The pending slot clears on commit, so cfg_ready rises the cycle after commit.
- Lock FSM, states SETTLE, LOCKED, PEND:
  - Reset → SETTLE with settle counter = LOCK_CYCLES−1.
  - SETTLE: count down; at 0 → LOCKED.
  - LOCKED: a valid in-range acceptance → PEND.
  - PEND: on commit → SETTLE (counter reloaded).
  - An in-range acceptance during SETTLE → PEND (the settle time restarts after commit).
  - locked = (state==LOCKED).
- Reset mid-operation (any state, any pending update): all state returns to its reset values on the next edge, and the pending update is discarded.

## Timing
- Reset values: strobe=0, toggle=0, locked=0, cfg_ready=1, cfg_err=0.
- With the first edge after rst deasserts as edge 1, channel i with divisor D asserts strobe in the cycle following edge D. It then repeats every D cycles. Channels with equal D are phase-aligned.
- locked rises after exactly LOCK_CYCLES edges following reset release, provided no config is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs except cfg_ready, which depends only on state.
- cfg_err has 1-cycle latency from acceptance.
- Commit latency is ≤ old_div cycles after acceptance.

## Structure
- Package clk_strobe_pkg contains:
  - the lock FSM state enum (SETTLE, LOCKED, PEND);
  - the localparam for cfg_ch width (4);
  - the helper function `init_div(i)` that extracts a DIV_INIT slice.
- Sub-module strobe_div_ch holds one channel: div, cnt, strobe and toggle registers, plus commit inputs (load_en, load_div) and a terminal-count output.
- The top level instantiates NUM_CH copies via generate and contains the handshake, pending slot and lock FSM.

## Test plan
- Reset with DIV_INIT={4,3,2,0}, LOCK_CYCLES=8:
  - ch0 strobes at cycles 4, 8, 12; ch1 at 3, 6, 9; ch2 at 2, 4, 6; ch3 stays low.
  - locked rises after 8 edges.
- ch0 at div=4 is reconfigured to 6 at cycle 5:
  - strobe still fires at cycle 8, then at 14 and 20;
  - cfg_ready is low from cycle 6 to commit;
  - locked drops and returns 8 cycles after commit.
- Request with cfg_ch=7 on NUM_CH=4: cfg_err pulses for 1 cycle, cfg_ready stays high, locked stays high, and no channel changes.
- Enable a disabled channel (div 0→5): commit on the next cycle, first strobe 5 cycles later, and toggle has a period of 10.
- div=1 channel: strobe held high and toggle alternating every cycle. Then disable it: both outputs are low from the cycle after commit.
- Assert rst for 1 cycle while an update is pending: all outputs return to reset values and the pending update is never applied.
